// File: rtl/calc_arb.sv
// calc_arb: two-requester round-robin arbiter that sequences command/operand bytes onto a shared calculator device
// Ports: clk/rst (sync active-high); req, cmdN/opaN/opbN/nopN/rxN per requester in;
// gnt (one-hot grant), done (completion pulse), res (result), err (timeout) out;
// dev_cs/dev_din to the device, dev_busy/dev_drdy/dev_dout from the device.
module calc_arb #(
    parameter int DW  = 8,
    parameter int TMO = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req,
    input  logic [DW-1:0] cmd0,
    input  logic [DW-1:0] cmd1,
    input  logic [DW-1:0] opa0,
    input  logic [DW-1:0] opa1,
    input  logic [DW-1:0] opb0,
    input  logic [DW-1:0] opb1,
    input  logic [1:0]    nop0,
    input  logic [1:0]    nop1,
    input  logic          rx0,
    input  logic          rx1,
    output logic [1:0]    gnt,
    output logic [1:0]    done,
    output logic [DW-1:0] res,
    output logic          err,
    output logic          dev_cs,
    output logic [DW-1:0] dev_din,
    input  logic          dev_busy,
    input  logic          dev_drdy,
    input  logic [DW-1:0] dev_dout
);
    localparam int CW = $clog2(TMO + 1);
    typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_OP1, ST_OP2, ST_WAIT, ST_DONE} state_t;
    state_t        state_q, state_d;
    logic [1:0]    gnt_q, gnt_d;
    logic          ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] cmd_q, cmd_d, opa_q, opa_d, opb_q, opb_d, res_q, res_d;
    logic [1:0]    nop_q, nop_d;
    logic          rx_q, rx_d, err_q, err_d;
    logic          pick;
    // On a tie the requester not served last wins; ptr_q holds the last-served index.
    assign pick = (req == 2'b11) ? ~ptr_q : req[1];
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cmd_d   = cmd_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        nop_d   = nop_q;
        rx_d    = rx_q;
        res_d   = res_q;
        err_d   = err_q;
        // The counter only runs in WAIT, so it is zero on every WAIT entry.
        cnt_d   = (state_q == ST_WAIT) ? cnt_q + 1'b1 : '0;
        case (state_q)
            ST_IDLE: if (|req) begin
                state_d = ST_CMD;
                ptr_d   = pick;
                gnt_d   = pick ? 2'b10 : 2'b01;
                cmd_d   = pick ? cmd1 : cmd0;
                opa_d   = pick ? opa1 : opa0;
                opb_d   = pick ? opb1 : opb0;
                nop_d   = pick ? nop1 : nop0;
                rx_d    = pick ? rx1 : rx0;
            end
            ST_CMD:  state_d = (nop_q == 2'd0) ? ST_WAIT : ST_OP1;
            ST_OP1:  state_d = (nop_q == 2'd1) ? ST_WAIT : ST_OP2;
            ST_OP2:  state_d = ST_WAIT;
            ST_WAIT: begin
                // Completion outranks the timeout; busy is ignored on the first WAIT cycle.
                if (rx_q && dev_drdy) begin
                    res_d   = dev_dout;
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (!rx_q && !dev_busy && cnt_q != '0) begin
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (cnt_q == CW'(TMO - 1)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                gnt_d   = 2'b00;
            end
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= 2'b00;
            ptr_q   <= 1'b1;
            cnt_q   <= '0;
            cmd_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            nop_q   <= 2'd0;
            rx_q    <= 1'b0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            nop_q   <= nop_d;
            rx_q    <= rx_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end
    assign gnt     = gnt_q;
    assign done    = (state_q == ST_DONE) ? gnt_q : 2'b00;
    assign res     = res_q;
    assign err     = err_q;
    assign dev_cs  = (state_q == ST_CMD);
    assign dev_din = (state_q == ST_CMD) ? cmd_q :
                     (state_q == ST_OP1) ? opa_q :
                     (state_q == ST_OP2) ? opb_q : '0;
endmodule

// File: tb/tb_calc_arb.sv
// tb_calc_arb: directed self-checking bench for calc_arb
module tb_calc_arb;
    localparam int DW  = 8;
    localparam int TMO = 15;
    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req;
    logic [DW-1:0] cmd0, cmd1, opa0, opa1, opb0, opb1;
    logic [1:0]    nop0, nop1;
    logic          rx0, rx1;
    logic [1:0]    gnt, done;
    logic [DW-1:0] res;
    logic          err;
    logic          dev_cs;
    logic [DW-1:0] dev_din;
    logic          dev_busy, dev_drdy;
    logic [DW-1:0] dev_dout;
    int            passed = 0;
    int            total  = 0;
    calc_arb #(.DW(DW), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .req(req),
        .cmd0(cmd0), .cmd1(cmd1), .opa0(opa0), .opa1(opa1), .opb0(opb0), .opb1(opb1),
        .nop0(nop0), .nop1(nop1), .rx0(rx0), .rx1(rx1),
        .gnt(gnt), .done(done), .res(res), .err(err),
        .dev_cs(dev_cs), .dev_din(dev_din),
        .dev_busy(dev_busy), .dev_drdy(dev_drdy), .dev_dout(dev_dout)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask
    initial begin
        rst = 1'b1; req = 2'b11;
        cmd0 = 8'hF0; opa0 = 8'h05; opb0 = 8'h03; nop0 = 2'd2; rx0 = 1'b1;
        cmd1 = 8'hA1; opa1 = 8'h11; opb1 = 8'h22; nop1 = 2'd0; rx1 = 1'b1;
        dev_busy = 1'b0; dev_drdy = 1'b0; dev_dout = 8'h00;
        tick(); tick();
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_done", done, 2'b00);
        chk("rst_res", res, 8'h00);
        chk("rst_err", err, 1'b0);
        chk("rst_cs", dev_cs, 1'b0);
        chk("rst_din", dev_din, 8'h00);
        rst = 1'b0;
        tick();
        chk("t1_gnt", gnt, 2'b01);
        chk("t2_cs_cmd", dev_cs, 1'b1);
        chk("t2_din_cmd", dev_din, 8'hF0);
        req = 2'b00;
        tick();
        chk("t2_cs_op1", dev_cs, 1'b0);
        chk("t2_din_op1", dev_din, 8'h05);
        tick();
        chk("t2_cs_op2", dev_cs, 1'b0);
        chk("t2_din_op2", dev_din, 8'h03);
        tick();
        chk("t2_din_wait", dev_din, 8'h00);
        chk("t2_done_w1", done, 2'b00);
        tick();
        chk("t2_done_w2", done, 2'b00);
        dev_drdy = 1'b1; dev_dout = 8'h08;
        tick();
        dev_drdy = 1'b0;
        chk("t2_done", done, 2'b01);
        chk("t2_res", res, 8'h08);
        chk("t2_err", err, 1'b0);
        chk("t2_gnt_done", gnt, 2'b01);
        tick();
        chk("t2_gnt_idle", gnt, 2'b00);
        chk("t2_done_off", done, 2'b00);
        nop0 = 2'd0;
        dev_drdy = 1'b1;
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            dev_dout = 8'h10 + 8'(i);
            tick();
            chk("t3_gnt", gnt, (i % 2 == 0) ? 2'b10 : 2'b01);
            tick();
            chk("t3_wait_done", done, 2'b00);
            tick();
            chk("t3_done", done, (i % 2 == 0) ? 2'b10 : 2'b01);
            chk("t3_res", res, 8'h10 + i);
            tick();
            chk("t3_idle_gnt", gnt, 2'b00);
        end
        req = 2'b00; dev_drdy = 1'b0;
        rx1 = 1'b0; dev_busy = 1'b1;
        tick();
        req = 2'b10;
        tick();
        chk("t4_gnt", gnt, 2'b10);
        chk("t4_din", dev_din, 8'hA1);
        req = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_busy_wait", done, 2'b00);
        end
        dev_busy = 1'b0;
        tick();
        chk("t4_done", done, 2'b10);
        chk("t4_res_kept", res, 8'h13);
        chk("t4_err", err, 1'b0);
        tick();
        req = 2'b01;
        tick();
        chk("t5_gnt", gnt, 2'b01);
        req = 2'b00;
        tick();
        for (int i = 1; i < TMO; i++) begin
            tick();
            chk("t5_no_done", done, 2'b00);
        end
        tick();
        chk("t5_done", done, 2'b01);
        chk("t5_err", err, 1'b1);
        chk("t5_res", res, 8'h00);
        tick();
        chk("t5_idle", done, 2'b00);
        nop0 = 2'd2;
        req = 2'b01;
        tick();
        chk("t6_gnt", gnt, 2'b01);
        tick();
        chk("t6_op1", dev_din, 8'h05);
        rst = 1'b1;
        tick();
        chk("t6_rst_done", done, 2'b00);
        chk("t6_rst_cs", dev_cs, 1'b0);
        chk("t6_rst_gnt", gnt, 2'b00);
        chk("t6_rst_din", dev_din, 8'h00);
        rst = 1'b0;
        dev_drdy = 1'b1; dev_dout = 8'h5A;
        tick();
        chk("t6_regnt", gnt, 2'b01);
        chk("t6_cmd", dev_din, 8'hF0);
        req = 2'b00;
        tick(); tick(); tick();
        chk("t6_wait", done, 2'b00);
        tick();
        chk("t6_done", done, 2'b01);
        chk("t6_res", res, 8'h5A);
        chk("t6_err", err, 1'b0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
